// File: rtl/balance_pkg.sv
// Shared widths, limits and helpers for the balance controller datapath.
package balance_pkg;

    localparam int ERR_W   = 10;
    localparam int INTEG_W = 18;
    localparam int SPD_W   = 12;
    localparam int DIFF_W  = 7;
    localparam int PID_W   = 16;

    // Speed command above which the rider is warned of over-speed.
    localparam logic signed [SPD_W-1:0] TOO_FAST_THRESH = 12'sd1536;

    // Largest value representable in a w-bit two's-complement word.
    function automatic int sat_max(input int w);
        return (1 <<< (w - 1)) - 1;
    endfunction

    // Smallest value representable in a w-bit two's-complement word.
    function automatic int sat_min(input int w);
        return -(1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/balance_sat.sv
// Generic signed saturator: clamps an IN_W-bit value into OUT_W bits.
module balance_sat
    import balance_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 10
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout
);

    localparam logic signed [IN_W-1:0] MAX_IN = IN_W'(sat_max(OUT_W));
    localparam logic signed [IN_W-1:0] MIN_IN = IN_W'(sat_min(OUT_W));

    // Clamp to the output range, otherwise pass the low bits through.
    always_comb begin
        dout = din[OUT_W-1:0];
        if (din > MAX_IN) begin
            dout = OUT_W'(sat_max(OUT_W));
        end else if (din < MIN_IN) begin
            dout = OUT_W'(sat_min(OUT_W));
        end
    end

endmodule

// File: rtl/balance_cntrl.sv
// Balance controller: PID on fused pitch plus load-cell steering, producing
// registered signed left/right speed commands and an over-speed flag.
module balance_cntrl
    import balance_pkg::*;
#(
    parameter logic signed [4:0] P_COEFF = 5'sh0C,
    parameter logic signed [5:0] D_COEFF = 6'sh07
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vld,
    input  logic [15:0] ptch,
    input  logic [11:0] ld_cell_diff,
    input  logic        rider_off,
    input  logic        en_steer,
    output logic [11:0] lft_spd,
    output logic [11:0] rght_spd,
    output logic        too_fast
);

    logic signed [ERR_W-1:0]   err_sat;
    logic signed [ERR_W-1:0]   err_q0;
    logic signed [ERR_W-1:0]   err_q1;
    logic signed [INTEG_W-1:0] integ;
    logic signed [INTEG_W-1:0] integ_sum;
    logic                      integ_ovf;
    logic                      vld_d;

    logic signed [14:0]        p_term;
    logic signed [14:0]        i_term;
    logic signed [ERR_W:0]     d_diff;
    logic signed [DIFF_W-1:0]  d_sat;
    logic signed [12:0]        d_term;
    logic signed [PID_W-1:0]   pid;
    logic signed [11:0]        ld_shift;
    logic signed [PID_W-1:0]   steer;
    logic signed [PID_W-1:0]   lft_raw;
    logic signed [PID_W-1:0]   rght_raw;
    logic signed [SPD_W-1:0]   lft_sat;
    logic signed [SPD_W-1:0]   rght_sat;
    logic                      too_fast_nxt;

    balance_sat #(.IN_W(16), .OUT_W(ERR_W)) u_sat_err (
        .din  ($signed(ptch)),
        .dout (err_sat)
    );

    // Integrator sum; a same-sign add that flips the sign would wrap, so it is held instead.
    always_comb begin
        integ_sum = integ + {{(INTEG_W-ERR_W){err_sat[ERR_W-1]}}, err_sat};
        integ_ovf = (integ[INTEG_W-1] == err_sat[ERR_W-1]) &&
                    (integ_sum[INTEG_W-1] != integ[INTEG_W-1]);
    end

    // P, I and raw D difference, all kept exact in their own widths.
    always_comb begin
        p_term = {{5{err_q0[ERR_W-1]}}, err_q0} * {{10{P_COEFF[4]}}, P_COEFF};
        i_term = {{3{integ[INTEG_W-1]}}, integ[INTEG_W-1:6]};
        d_diff = {err_q0[ERR_W-1], err_q0} - {err_q1[ERR_W-1], err_q1};
    end

    balance_sat #(.IN_W(ERR_W+1), .OUT_W(DIFF_W)) u_sat_diff (
        .din  (d_diff),
        .dout (d_sat)
    );

    // Sum PID and apply the steering differential from the load cells.
    always_comb begin
        d_term   = {{6{d_sat[DIFF_W-1]}}, d_sat} * {{7{D_COEFF[5]}}, D_COEFF};
        pid      = {p_term[14], p_term} + {i_term[14], i_term} +
                   {{3{d_term[12]}}, d_term};
        ld_shift = $signed(ld_cell_diff) >>> 3;
        steer    = {{4{ld_shift[11]}}, ld_shift};
        lft_raw  = pid;
        rght_raw = pid;
        if (en_steer) begin
            lft_raw  = pid - steer;
            rght_raw = pid + steer;
        end
    end

    balance_sat #(.IN_W(PID_W), .OUT_W(SPD_W)) u_sat_lft (
        .din  (lft_raw),
        .dout (lft_sat)
    );

    balance_sat #(.IN_W(PID_W), .OUT_W(SPD_W)) u_sat_rght (
        .din  (rght_raw),
        .dout (rght_sat)
    );

    // Over-speed when either saturated command exceeds the threshold.
    always_comb begin
        too_fast_nxt = (lft_sat > TOO_FAST_THRESH) || (rght_sat > TOO_FAST_THRESH);
    end

    // Error history and delayed valid; history keeps moving even with no rider.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q0 <= '0;
            err_q1 <= '0;
            vld_d  <= 1'b0;
        end else begin
            vld_d <= vld;
            if (vld) begin
                err_q1 <= err_q0;
                err_q0 <= err_sat;
            end
        end
    end

    // Integrator: rider_off clears it and takes priority over a concurrent vld.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            integ <= '0;
        end else if (rider_off) begin
            integ <= '0;
        end else if (vld && !integ_ovf) begin
            integ <= integ_sum;
        end
    end

    // Output registers load one cycle after vld; rider_off forces them to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lft_spd  <= '0;
            rght_spd <= '0;
            too_fast <= 1'b0;
        end else if (rider_off) begin
            lft_spd  <= '0;
            rght_spd <= '0;
            too_fast <= 1'b0;
        end else if (vld_d) begin
            lft_spd  <= lft_sat;
            rght_spd <= rght_sat;
            too_fast <= too_fast_nxt;
        end
    end

endmodule

// File: tb/tb_balance_cntrl.sv
// Self-checking bench for balance_cntrl: vector table plus hand sequences,
// with expected outputs queued at drive time and checked when they appear.
module tb_balance_cntrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0;
    logic [15:0] ptch = '0;
    logic [11:0] ld_cell_diff = '0;
    logic        rider_off = 1'b0;
    logic        en_steer = 1'b0;
    logic [11:0] lft_spd;
    logic [11:0] rght_spd;
    logic        too_fast;

    balance_cntrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .vld          (vld),
        .ptch         (ptch),
        .ld_cell_diff (ld_cell_diff),
        .rider_off    (rider_off),
        .en_steer     (en_steer),
        .lft_spd      (lft_spd),
        .rght_spd     (rght_spd),
        .too_fast     (too_fast)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   l;
        int   r;
        logic tf;
    } exp_t;

    typedef struct {
        logic [15:0] p;
        logic [11:0] ld;
        logic        en;
        int          l;
        int          r;
        logic        tf;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    vec_t vecs[10];

    int n_cmp = 0;
    int n_bad = 0;

    logic vld_p1 = 1'b0;
    logic vld_p2 = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Output appears after the second rising edge following a vld pulse.
    always @(posedge clk) begin
        vld_p1 <= vld;
        vld_p2 <= vld_p1;
    end

    always @(negedge clk) begin
        if (vld_p2) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_empty: output update with no expected entry (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                chk("lft_spd", int'($signed(lft_spd)), mon_e.l);
                chk("rght_spd", int'($signed(rght_spd)), mon_e.r);
                chk("too_fast", int'(too_fast), int'(mon_e.tf));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        vld = 1'b0;
        rider_off = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulse(input logic [15:0] p, input int l, input int r, input logic tf);
        exp_t e;
        e.l = l;
        e.r = r;
        e.tf = tf;
        ptch = p;
        vld = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        vld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{16'h0010, 12'h000, 1'b0,   304,   304, 1'b0};
        vecs[1] = '{16'h7FFF, 12'h000, 1'b0,  2047,  2047, 1'b1};
        vecs[2] = '{16'h8000, 12'h000, 1'b0, -2048, -2048, 1'b0};
        vecs[3] = '{16'h0000, 12'h100, 1'b1,   -32,    32, 1'b0};
        vecs[4] = '{16'h0000, 12'h100, 1'b0,     0,     0, 1'b0};
        vecs[5] = '{16'hFFF0, 12'h000, 1'b0,  -305,  -305, 1'b0};
        vecs[6] = '{16'h005B, 12'h010, 1'b1,  1532,  1536, 1'b0};
        vecs[7] = '{16'h005B, 12'h018, 1'b1,  1531,  1537, 1'b1};
        vecs[8] = '{16'h0000, 12'hF00, 1'b1,    32,   -32, 1'b0};
        vecs[9] = '{16'h0000, 12'hFFF, 1'b1,     1,    -1, 1'b0};

        // Single-pulse vectors, each from a fresh reset.
        for (int i = 0; i < 10; i++) begin
            do_reset();
            chk("rst_lft", int'($signed(lft_spd)), 0);
            chk("rst_rght", int'($signed(rght_spd)), 0);
            chk("rst_too_fast", int'(too_fast), 0);
            en_steer = vecs[i].en;
            ld_cell_diff = vecs[i].ld;
            pulse(vecs[i].p, vecs[i].l, vecs[i].r, vecs[i].tf);
            repeat (3) @(negedge clk);
        end

        // Back-to-back pulses drive the integrator to its overflow hold point.
        do_reset();
        en_steer = 1'b0;
        ld_cell_diff = '0;
        for (int i = 0; i < 300; i++) begin
            pulse(16'h01FF, 2047, 2047, 1'b1);
            vld = (i != 299);
            if (i != 299) begin
                // keep vld asserted across the boundary for true back-to-back timing
            end
        end
        vld = 1'b0;
        repeat (3) @(negedge clk);
        // Integrator held at 130816 gives I=2044; first zero pulse adds D=-448.
        pulse(16'h0000, 1596, 1596, 1'b1);
        repeat (3) @(negedge clk);
        pulse(16'h0000, 2044, 2044, 1'b1);
        repeat (3) @(negedge clk);

        // rider_off concurrent with vld clears integrator and outputs at once.
        ptch = 16'h0010;
        vld = 1'b1;
        rider_off = 1'b1;
        sb.push_back('{0, 0, 1'b0});
        @(negedge clk);
        vld = 1'b0;
        chk("ro_lft", int'($signed(lft_spd)), 0);
        chk("ro_rght", int'($signed(rght_spd)), 0);
        chk("ro_too_fast", int'(too_fast), 0);
        @(negedge clk);
        rider_off = 1'b0;
        repeat (2) @(negedge clk);
        // Integrator restarted from zero: only D from 0-16 remains.
        pulse(16'h0000, -112, -112, 1'b0);
        repeat (3) @(negedge clk);
        pulse(16'h0000, 0, 0, 1'b0);
        repeat (3) @(negedge clk);

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: %0d expected entries never produced, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
